// File: rtl/mc_arb_pkg.sv
// Shared types and constants for the MC port arbiter: FSM states, MC command
// encodings, request/response field widths and the response FIFO entry.
package mc_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int VADR_W = 48;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 2;
  localparam int CMD_W  = 3;
  localparam int SCMD_W = 4;

  localparam logic [CMD_W-1:0] MC_CMD_IDLE = 3'd0;
  localparam logic [CMD_W-1:0] MC_CMD_RD   = 3'd1;
  localparam logic [CMD_W-1:0] MC_CMD_WR   = 3'd2;

  // Response payload; rtnctl travels beside it because its width is a module parameter.
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [SCMD_W-1:0] scmd;
    logic [DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/mc_rsp_fifo.sv
// Synchronous FIFO holding MC responses until the addressed requester takes them.
// Exposes its occupancy so the owner can raise backpressure early.
module mc_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // The MC must honour the early stall; overrunning the FIFO is a protocol violation.
  assert property (@(posedge clk) disable iff (i_reset) !(push && full));

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one MC port among NUM_REQ requesters: round-robin request arbitration,
// ID-tagged response routing through a FIFO, and write-flush sequencing.
module mc_port_arbiter
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int RTNCTL_WIDTH = 32,
  parameter int RS_DEPTH     = 8,
  parameter int RS_SLACK     = 4,
  localparam int TAG_W       = RTNCTL_WIDTH - ID_W
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          req_vld,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ*VADR_W-1:0]   req_vadr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*SIZE_W-1:0]   req_size,
  input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
  input  logic [NUM_REQ*SCMD_W-1:0]   req_scmd,
  input  logic [NUM_REQ*TAG_W-1:0]    req_rtnctl,
  output logic [NUM_REQ-1:0]          rsp_vld,
  input  logic [NUM_REQ-1:0]          rsp_rdy,
  output logic [CMD_W-1:0]            rsp_cmd,
  output logic [SCMD_W-1:0]           rsp_scmd,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [TAG_W-1:0]            rsp_rtnctl,
  input  logic [NUM_REQ-1:0]          flush_req,
  output logic [NUM_REQ-1:0]          flush_done,
  output logic                        mc_rq_vld,
  output logic [RTNCTL_WIDTH-1:0]     mc_rq_rtnctl,
  output logic [DATA_W-1:0]           mc_rq_data,
  output logic [VADR_W-1:0]           mc_rq_vadr,
  output logic [SIZE_W-1:0]           mc_rq_size,
  output logic [CMD_W-1:0]            mc_rq_cmd,
  output logic [SCMD_W-1:0]           mc_rq_scmd,
  input  logic                        mc_rq_stall,
  input  logic                        mc_rs_vld,
  input  logic [CMD_W-1:0]            mc_rs_cmd,
  input  logic [SCMD_W-1:0]           mc_rs_scmd,
  input  logic [DATA_W-1:0]           mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]     mc_rs_rtnctl,
  output logic                        mc_rs_stall,
  output logic                        mc_rq_flush,
  input  logic                        mc_rs_flush_cmplt,
  output arb_state_t                  dbg_state
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;
  localparam int ENT_W = $bits(rsp_entry_t) + RTNCTL_WIDTH;
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(RS_DEPTH - RS_SLACK);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, win_id, flush_id, flush_id_q;
  logic            grant_en, grant, flush_any, drained;

  // First valid requester at or above ptr, wrapping; later offsets are overwritten.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    int idx;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (vld[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign flush_any = |flush_req;
  assign drained   = !mc_rq_vld;
  assign dbg_state = state_q;

  always_comb begin
    flush_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (flush_req[i]) flush_id = ID_W'(i);
  end

  always_ff @(posedge clk) begin
    if (i_reset) state_q <= ARB;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (flush_any) state_d = DRAIN;
      DRAIN:   if (drained) state_d = WAIT;
      WAIT:    if (mc_rs_flush_cmplt) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    grant_en    = 1'b0;
    mc_rq_flush = 1'b0;
    flush_done  = '0;
    case (state_q)
      ARB:     grant_en = !flush_any && !mc_rq_stall && !i_reset;
      DRAIN:   mc_rq_flush = drained;
      WAIT:    if (mc_rs_flush_cmplt && !i_reset) flush_done = NUM_REQ'(1) << flush_id_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset)                        flush_id_q <= '0;
    else if (state_q == ARB && flush_any) flush_id_q <= flush_id;
  end

  // Handshake: a request transfers in any cycle where req_vld[i] && req_rdy[i];
  // req_rdy is at most one-hot and never depends on the requester's own data.
  assign win_id  = rr_pick(req_vld, rr_ptr_q);
  assign grant   = grant_en && |req_vld;
  assign req_rdy = grant ? (NUM_REQ'(1) << win_id) : '0;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rr_ptr_q     <= '0;
      mc_rq_vld    <= 1'b0;
      mc_rq_rtnctl <= '0;
      mc_rq_data   <= '0;
      mc_rq_vadr   <= '0;
      mc_rq_size   <= '0;
      mc_rq_cmd    <= '0;
      mc_rq_scmd   <= '0;
    end else begin
      mc_rq_vld <= grant;
      if (grant) begin
        rr_ptr_q     <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        mc_rq_rtnctl <= {win_id, req_rtnctl[win_id*TAG_W +: TAG_W]};
        mc_rq_data   <= req_data[win_id*DATA_W +: DATA_W];
        mc_rq_vadr   <= req_vadr[win_id*VADR_W +: VADR_W];
        mc_rq_size   <= req_size[win_id*SIZE_W +: SIZE_W];
        mc_rq_cmd    <= req_cmd[win_id*CMD_W +: CMD_W];
        mc_rq_scmd   <= req_scmd[win_id*SCMD_W +: SCMD_W];
      end
    end
  end

  rsp_entry_t              head_ent;
  logic [RTNCTL_WIDTH-1:0] head_rtn;
  logic [ENT_W-1:0]        fifo_wdata, fifo_rdata;
  logic [ID_W-1:0]         head_id;
  logic                    fifo_empty, fifo_pop;
  logic [CNT_W-1:0]        fifo_cnt, cnt_next;

  assign fifo_wdata = {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl};
  assign {head_ent, head_rtn} = fifo_rdata;
  assign head_id    = head_rtn[RTNCTL_WIDTH-1 -: ID_W];
  assign fifo_pop   = !fifo_empty && rsp_rdy[head_id];
  assign rsp_vld    = fifo_empty ? '0 : (NUM_REQ'(1) << head_id);
  assign rsp_cmd    = fifo_empty ? '0 : head_ent.cmd;
  assign rsp_scmd   = fifo_empty ? '0 : head_ent.scmd;
  assign rsp_data   = fifo_empty ? '0 : head_ent.data;
  assign rsp_rtnctl = fifo_empty ? '0 : head_rtn[TAG_W-1:0];

  mc_rsp_fifo #(
    .DEPTH (RS_DEPTH),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .push    (mc_rs_vld),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Stall looks at next cycle's occupancy so RS_SLACK entries remain for in-flight responses.
  always_comb begin
    cnt_next = fifo_cnt;
    if (mc_rs_vld && !fifo_pop)      cnt_next = fifo_cnt + CNT_W'(1);
    else if (!mc_rs_vld && fifo_pop) cnt_next = fifo_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (i_reset) mc_rs_stall <= 1'b0;
    else         mc_rs_stall <= (cnt_next >= STALL_LVL);
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Bench for mc_port_arbiter: table vectors, hand sequences for stall/flush/reset,
// and random traffic checked against a queue-based reference model.
module tb_mc_port_arbiter;
  import mc_arb_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int RTNCTL_WIDTH = 32;
  localparam int RS_DEPTH     = 8;
  localparam int RS_SLACK     = 4;
  localparam int TAG_W        = RTNCTL_WIDTH - ID_W;
  localparam int PKT_W = RTNCTL_WIDTH + VADR_W + DATA_W + SIZE_W + CMD_W + SCMD_W;
  localparam int ENT_W = CMD_W + SCMD_W + DATA_W + RTNCTL_WIDTH;

  logic                        clk;
  logic                        i_reset;
  logic [NUM_REQ-1:0]          req_vld, req_rdy;
  logic [NUM_REQ*VADR_W-1:0]   req_vadr;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ*SIZE_W-1:0]   req_size;
  logic [NUM_REQ*CMD_W-1:0]    req_cmd;
  logic [NUM_REQ*SCMD_W-1:0]   req_scmd;
  logic [NUM_REQ*TAG_W-1:0]    req_rtnctl;
  logic [NUM_REQ-1:0]          rsp_vld, rsp_rdy;
  logic [CMD_W-1:0]            rsp_cmd;
  logic [SCMD_W-1:0]           rsp_scmd;
  logic [DATA_W-1:0]           rsp_data;
  logic [TAG_W-1:0]            rsp_rtnctl;
  logic [NUM_REQ-1:0]          flush_req, flush_done;
  logic                        mc_rq_vld;
  logic [RTNCTL_WIDTH-1:0]     mc_rq_rtnctl;
  logic [DATA_W-1:0]           mc_rq_data;
  logic [VADR_W-1:0]           mc_rq_vadr;
  logic [SIZE_W-1:0]           mc_rq_size;
  logic [CMD_W-1:0]            mc_rq_cmd;
  logic [SCMD_W-1:0]           mc_rq_scmd;
  logic                        mc_rq_stall;
  logic                        mc_rs_vld;
  logic [CMD_W-1:0]            mc_rs_cmd;
  logic [SCMD_W-1:0]           mc_rs_scmd;
  logic [DATA_W-1:0]           mc_rs_data;
  logic [RTNCTL_WIDTH-1:0]     mc_rs_rtnctl;
  logic                        mc_rs_stall;
  logic                        mc_rq_flush;
  logic                        mc_rs_flush_cmplt;
  arb_state_t                  dbg_state;

  mc_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .RTNCTL_WIDTH(RTNCTL_WIDTH),
    .RS_DEPTH(RS_DEPTH), .RS_SLACK(RS_SLACK)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_vadr(req_vadr), .req_data(req_data),
    .req_size(req_size), .req_cmd(req_cmd), .req_scmd(req_scmd), .req_rtnctl(req_rtnctl),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_cmd(rsp_cmd), .rsp_scmd(rsp_scmd),
    .rsp_data(rsp_data), .rsp_rtnctl(rsp_rtnctl),
    .flush_req(flush_req), .flush_done(flush_done),
    .mc_rq_vld(mc_rq_vld), .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_cmd(mc_rq_cmd),
    .mc_rq_scmd(mc_rq_scmd), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
    .mc_rq_flush(mc_rq_flush), .mc_rs_flush_cmplt(mc_rs_flush_cmplt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus knobs and expected flush outputs
  logic [NUM_REQ-1:0] s_vld, s_rdy, s_flush, exp_done;
  logic               s_stall, s_push, s_cmplt, exp_flush;
  logic [ENT_W-1:0]   s_ent;

  // Reference model: RR position, issued-request queue, response queue
  int                 m_ptr;
  logic               m_block;
  logic               m_stall;
  logic [PKT_W-1:0]   exp_q[$];
  logic [ENT_W-1:0]   rs_q[$];

  logic [VADR_W-1:0]  r_vadr [NUM_REQ];
  logic [DATA_W-1:0]  r_data [NUM_REQ];
  logic [SIZE_W-1:0]  r_size [NUM_REQ];
  logic [CMD_W-1:0]   r_cmd  [NUM_REQ];
  logic [SCMD_W-1:0]  r_scmd [NUM_REQ];
  logic [TAG_W-1:0]   r_tag  [NUM_REQ];

  typedef struct {
    logic [NUM_REQ-1:0] vld;
    logic               stall;
    logic [NUM_REQ-1:0] exp_rdy;
  } arb_vec_t;
  arb_vec_t vecs[12];

  task automatic check(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] make_ent(input int id);
    return {CMD_W'($urandom()), SCMD_W'($urandom()), $urandom(), $urandom(), ID_W'(id), TAG_W'($urandom())};
  endfunction

  task automatic drive_req_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      r_vadr[i] = VADR_W'({$urandom(), $urandom()});
      r_data[i] = {$urandom(), $urandom()};
      r_size[i] = SIZE_W'($urandom());
      r_cmd[i]  = ($urandom_range(0, 1) != 0) ? MC_CMD_RD : MC_CMD_WR;
      r_scmd[i] = SCMD_W'($urandom());
      r_tag[i]  = TAG_W'($urandom());
      req_vadr[i*VADR_W +: VADR_W] = r_vadr[i];
      req_data[i*DATA_W +: DATA_W] = r_data[i];
      req_size[i*SIZE_W +: SIZE_W] = r_size[i];
      req_cmd[i*CMD_W +: CMD_W]    = r_cmd[i];
      req_scmd[i*SCMD_W +: SCMD_W] = r_scmd[i];
      req_rtnctl[i*TAG_W +: TAG_W] = r_tag[i];
    end
  endtask

  // Driver + scoreboard for one clock: drive after the edge, check at the falling edge.
  task automatic run_cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [ENT_W-1:0]   head;
    logic [ID_W-1:0]    hid;
    int                 win;
    @(posedge clk); #1;
    drive_req_fields();
    req_vld = s_vld;  mc_rq_stall = s_stall;  rsp_rdy = s_rdy;
    flush_req = s_flush;  mc_rs_flush_cmplt = s_cmplt;  mc_rs_vld = s_push;
    {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl} = s_ent;
    @(negedge clk);
    check("mc_rq_vld", mc_rq_vld, exp_q.size() != 0);
    if (exp_q.size() != 0)
      check("mc_rq_pkt", {mc_rq_rtnctl, mc_rq_vadr, mc_rq_data, mc_rq_size, mc_rq_cmd, mc_rq_scmd},
            exp_q.pop_front());
    win = -1;
    if (!s_stall && !m_block)
      for (int k = 0; k < NUM_REQ; k++)
        if (win < 0 && s_vld[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
    exp_rdy = (win < 0) ? '0 : (NUM_REQ'(1) << win);
    check("req_rdy", req_rdy, exp_rdy);
    if (win >= 0) begin
      exp_q.push_back({ID_W'(win), r_tag[win], r_vadr[win], r_data[win], r_size[win], r_cmd[win], r_scmd[win]});
      m_ptr = (win + 1) % NUM_REQ;
    end
    check("mc_rs_stall", mc_rs_stall, m_stall);
    if (rs_q.size() == 0) begin
      check("rsp_vld_idle", rsp_vld, '0);
    end else begin
      head = rs_q[0];
      hid  = head[RTNCTL_WIDTH-1 -: ID_W];
      check("rsp_vld", rsp_vld, NUM_REQ'(1) << hid);
      check("rsp_payload", {rsp_cmd, rsp_scmd, rsp_data, rsp_rtnctl},
            {head[ENT_W-1:RTNCTL_WIDTH], head[TAG_W-1:0]});
      if (s_rdy[hid]) void'(rs_q.pop_front());
    end
    if (s_push) rs_q.push_back(s_ent);
    m_stall = (rs_q.size() >= RS_DEPTH - RS_SLACK);
    check("mc_rq_flush", mc_rq_flush, exp_flush);
    check("flush_done", flush_done, exp_done);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_rdy"}, req_rdy, '0);
    check({tag, "_mc_rq_vld"}, mc_rq_vld, '0);
    check({tag, "_mc_rq_rtnctl"}, mc_rq_rtnctl, '0);
    check({tag, "_mc_rq_vadr"}, mc_rq_vadr, '0);
    check({tag, "_mc_rq_data"}, mc_rq_data, '0);
    check({tag, "_rsp_vld"}, rsp_vld, '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_mc_rs_stall"}, mc_rs_stall, '0);
    check({tag, "_mc_rq_flush"}, mc_rq_flush, '0);
    check({tag, "_flush_done"}, flush_done, '0);
    check({tag, "_state"}, dbg_state, ARB);
  endtask

  task automatic clear_stim();
    s_vld = '0; s_rdy = '0; s_flush = '0; exp_done = '0;
    s_stall = 1'b0; s_push = 1'b0; s_cmplt = 1'b0; exp_flush = 1'b0; s_ent = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_issue;
    clear_stim();
    req_vld = '0; rsp_rdy = '0; flush_req = '0; mc_rq_stall = 1'b0; mc_rs_vld = 1'b0;
    mc_rs_flush_cmplt = 1'b0; {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl} = '0;
    drive_req_fields();
    m_ptr = 0; m_block = 1'b0; m_stall = 1'b0;

    // Reset state
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Round-robin vectors starting from pointer 0
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0001, 1'b0, 4'b0001};
    vecs[6]  = '{4'b1001, 1'b0, 4'b1000};
    vecs[7]  = '{4'b0110, 1'b1, 4'b0000};
    vecs[8]  = '{4'b0110, 1'b0, 4'b0010};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[10] = '{4'b0110, 1'b0, 4'b0100};
    vecs[11] = '{4'b0011, 1'b0, 4'b0001};
    for (int i = 0; i < 12; i++) begin
      s_vld = vecs[i].vld; s_stall = vecs[i].stall;
      run_cycle();
      check($sformatf("tbl_rdy_%0d", i), req_rdy, vecs[i].exp_rdy);
    end
    clear_stim(); run_cycle();

    // Stall for 5 cycles in the middle of a saturated stream
    s_vld = '1;
    repeat (3) run_cycle();
    s_stall = 1'b1; n_issue = 0;
    repeat (5) begin run_cycle(); n_issue += int'(mc_rq_vld); end
    check("stall_issue_cnt", n_issue, 1);
    s_stall = 1'b0;
    repeat (3) run_cycle();
    clear_stim(); run_cycle();

    // Responses to IDs 1,3,0 with everyone ready
    s_rdy = '1;
    s_push = 1'b1; s_ent = make_ent(1); run_cycle();
    s_ent = make_ent(3); run_cycle();
    s_ent = make_ent(0); run_cycle();
    s_push = 1'b0; repeat (2) run_cycle();

    // Eight back-to-back responses for requester 2 while it is not ready
    s_rdy = 4'b1011;
    for (int j = 0; j < 8; j++) begin
      s_push = 1'b1; s_ent = make_ent(2);
      run_cycle();
      if (j == 3) check("rs_stall_after_3", mc_rs_stall, 1'b0);
      if (j == 4) check("rs_stall_after_4", mc_rs_stall, 1'b1);
    end
    s_push = 1'b0;
    repeat (2) run_cycle();
    check("hol_held_vld", rsp_vld, 4'b0100);
    check("hol_held_stall", mc_rs_stall, 1'b1);
    s_rdy = 4'b0100;
    repeat (10) run_cycle();
    check("hol_drained", rsp_vld, '0);
    clear_stim(); run_cycle();

    // Flush while a request sits in the output register
    s_vld = 4'b0001; run_cycle();
    s_vld = 4'b1111; s_flush = 4'b0010; m_block = 1'b1; run_cycle();
    exp_flush = 1'b1; s_cmplt = 1'b1; run_cycle();
    check("flush_state_drain", dbg_state, DRAIN);
    exp_flush = 1'b0; s_cmplt = 1'b0;
    for (int j = 0; j < 9; j++) begin
      run_cycle();
      if (j == 0) check("flush_state_wait", dbg_state, WAIT);
    end
    s_cmplt = 1'b1; exp_done = 4'b0010; run_cycle();
    s_cmplt = 1'b0; exp_done = '0; s_flush = '0; m_block = 1'b0;
    repeat (2) run_cycle();
    clear_stim(); run_cycle();

    // Two simultaneous flush requests served one after the other, lowest first
    s_flush = 4'b1010; m_block = 1'b1; run_cycle();
    exp_flush = 1'b1; run_cycle();
    exp_flush = 1'b0; s_cmplt = 1'b1; exp_done = 4'b0010; run_cycle();
    s_cmplt = 1'b0; exp_done = '0; s_flush = 4'b1000; run_cycle();
    exp_flush = 1'b1; run_cycle();
    exp_flush = 1'b0; s_cmplt = 1'b1; exp_done = 4'b1000; run_cycle();
    clear_stim(); m_block = 1'b0; run_cycle();

    // Reset with three queued responses and a flush outstanding
    s_push = 1'b1; s_ent = make_ent(2); s_flush = 4'b0001; m_block = 1'b1; run_cycle();
    s_ent = make_ent(2); exp_flush = 1'b1; run_cycle();
    s_ent = make_ent(2); exp_flush = 1'b0; run_cycle();
    s_push = 1'b0; run_cycle();
    check("pre_reset_state", dbg_state, WAIT);
    check("pre_reset_rsp_vld", rsp_vld, 4'b0100);
    @(posedge clk); #1;
    i_reset = 1'b1; mc_rs_flush_cmplt = 1'b1; flush_req = '0; mc_rs_vld = 1'b0; rsp_rdy = '0;
    @(negedge clk);
    check("reset_no_done", flush_done, '0);
    @(posedge clk); #1;
    i_reset = 1'b0; mc_rs_flush_cmplt = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    clear_stim();
    exp_q.delete(); rs_q.delete();
    m_ptr = 0; m_block = 1'b0; m_stall = 1'b0;
    run_cycle();

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      s_vld   = NUM_REQ'($urandom_range(0, 15));
      s_stall = ($urandom_range(0, 3) == 0);
      s_rdy   = NUM_REQ'($urandom_range(0, 15));
      s_push  = (rs_q.size() < RS_DEPTH) && ($urandom_range(0, 1) != 0);
      s_ent   = make_ent($urandom_range(0, NUM_REQ - 1));
      run_cycle();
    end
    clear_stim(); s_rdy = '1;
    repeat (RS_DEPTH + 2) run_cycle();
    check("final_rsp_vld", rsp_vld, '0);
    check("final_mc_rq_vld", mc_rq_vld, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
- Shares one Convey MC port (rq/rs/flush channels) among NUM_REQ personality requesters.
- Round-robin request arbitration; requester ID packed into the upper rtnctl bits; responses routed back by ID through a stall-tolerant response FIFO.
- Sequences write-flush on behalf of any requester.
- Instantiated inside PersonalityWrapper, one instance per MC port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width = clog2(NUM_REQ).
- RTNCTL_WIDTH, 32, MC rtnctl width; requesters own the low RTNCTL_WIDTH-ID_W bits.
- RS_DEPTH, 8, response FIFO depth (power of 2).
- RS_SLACK, 4, free entries kept when mc_rs_stall rises (MC stall-to-stop latency).

Ports:
- clk  in  1  personality clock.
- i_reset  in  1  synchronous active-high reset.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_vadr  in  NUM_REQ*48  virtual address.
- req_data  in  NUM_REQ*64  write data.
- req_size  in  NUM_REQ*2  size.
- req_cmd  in  NUM_REQ*3  command.
- req_scmd  in  NUM_REQ*4  sub-command.
- req_rtnctl  in  NUM_REQ*(RTNCTL_WIDTH-ID_W)  requester tag.
- rsp_vld  out  NUM_REQ  response valid, one-hot or zero.
- rsp_rdy  in  NUM_REQ  requester accepts response.
- rsp_cmd  out  3  response command, shared by all requesters.
- rsp_scmd  out  4  response sub-command, shared.
- rsp_data  out  64  response data, shared.
- rsp_rtnctl  out  RTNCTL_WIDTH-ID_W  response tag, shared.
- flush_req  in  NUM_REQ  level request to flush.
- flush_done  out  NUM_REQ  one-cycle completion pulse.
- mc_rq_vld, mc_rq_rtnctl, mc_rq_data, mc_rq_vadr, mc_rq_size, mc_rq_cmd, mc_rq_scmd  out  1/RTNCTL_WIDTH/64/48/2/3/4  MC request channel.
- mc_rq_stall  in  1  MC request stall.
- mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl  in  1/3/4/64/RTNCTL_WIDTH  MC response channel.
- mc_rs_stall  out  1  response backpressure.
- mc_rq_flush  out  1  flush request to MC.
- mc_rs_flush_cmplt  in  1  flush complete from MC.

Behaviour:

Reset:
- All outputs 0.
- RR pointer = 0; FIFO empty; FSM = ARB.
- Reset mid-transaction discards the output register and FIFO contents; no done pulses are issued.

Request path (FSM state ARB):
- Grant is computed when mc_rq_stall == 0 and at least one req_vld is high.
- Winner = first requester with req_vld high, searching from the RR pointer upward with wrap.
- req_rdy[winner] = 1 combinationally in that cycle.
- The request is registered; mc_rq_vld = 1 in the next cycle for exactly one cycle per grant.
- mc_rq_rtnctl = {winner ID, req_rtnctl}.
- RR pointer = winner+1 mod NUM_REQ.
- No grant while mc_rq_stall is high. At most one request (already registered) may issue in the cycle after stall rises.
- Throughput: 1 request per cycle.

Response path:
- mc_rs_vld pushes {cmd, scmd, data, rtnctl} into the FIFO.
- A push while full is an assertion error.
- Head ID = rtnctl[RTNCTL_WIDTH-1 -: ID_W].
- rsp_vld[head ID] = !empty.
- Pop when rsp_rdy[head ID] is high. Head-of-line blocking is accepted.
- mc_rs_stall is registered: 1 when count >= RS_DEPTH-RS_SLACK (counted after this cycle's push/pop), else 0.
- Simultaneous push and pop leaves count unchanged.
- Full-rate pass-through latency: 1 cycle from mc_rs_vld to rsp_vld.

Flush FSM:
- ARB: if any flush_req is high, capture the lowest-index requester with flush_req high, stop granting, go to DRAIN.
- DRAIN: wait until the output register is empty (its last mc_rq_vld has issued), then drive mc_rq_flush = 1 for one cycle, go to WAIT.
- WAIT: on mc_rs_flush_cmplt, pulse flush_done[captured] for 1 cycle, go to ARB.
- flush_req must drop in the cycle after flush_done.
- Flush requests from other requesters are served sequentially.
- mc_rs_flush_cmplt outside WAIT is ignored.
- Responses keep draining in every state.

Decomposition:
- Package mc_arb_pkg:
  - FSM enum {ARB, DRAIN, WAIT}.
  - MC command encodings (RD=1, WR=2, ...).
  - Field widths 48/64/2/3/4.
  - Response entry struct.
- Sub-module mc_rsp_fifo: synchronous FIFO with count output, parameterised on depth and width.

Test Plan:
1. All 4 requesters hold req_vld, stall=0 -> grants in order 0,1,2,3,0 on consecutive cycles; mc_rq_rtnctl[31:30] = 0,1,2,3,0.
2. Stall raised for 5 cycles during a stream -> at most 1 mc_rq_vld after the rise, none for the remainder; grants resume at the RR position, with no request lost or duplicated.
3. MC returns 8 responses back-to-back with rtnctl[31:30]=2 and rsp_rdy[2]=0 -> mc_rs_stall=1 after the 4th push; all 8 are held; releasing rsp_rdy delivers them in order.
4. Responses with IDs 1,3,0 and all rsp_rdy=1 -> each appears on the matching rsp_vld bit 1 cycle later with the low 30 rtnctl bits intact.
5. flush_req[1] rises while a request is in the output register -> that request issues, then mc_rq_flush pulses; mc_rs_flush_cmplt 10 cycles later -> flush_done[1] pulses 1 cycle; no grants until then.
6. i_reset asserted with 3 FIFO entries and the FSM in WAIT -> next cycle all outputs 0, FSM=ARB, FIFO empty, no flush_done pulse.
